// File: rtl/prog_clk_divider.sv
// Programmable-ratio clock divider.
// Produces a registered divided clock, a one-cycle terminal tick per period
// and a running flag. New ratios arrive over a valid/ready handshake and only
// take effect on period boundaries, so a period is never truncated.
module prog_clk_divider #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         io_en,
    input  logic         io_cfgValid,
    output logic         io_cfgReady,
    input  logic [W-1:0] io_cfgDiv,
    output logic         io_divClk,
    output logic         io_tick,
    output logic         io_running,
    output logic [W-1:0] io_curDiv
);

    // STOPPED: idle, ratio writable directly.
    // RUN:     producing periods, ratio request accepted.
    // PEND:    producing periods with a ratio parked for the next boundary.
    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_PEND    = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] MIN_DIV = W'(2);
    localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);

    // Ratios below 2 would give a zero-length phase, so they are raised to 2.
    function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    state_t         r_state;
    logic [W-1:0]   r_cnt;
    logic [W-1:0]   r_div;
    logic [W-1:0]   r_pend;
    logic           r_div_clk;
    logic           r_tick;
    logic           r_running;

    state_t         w_state_next;
    logic [W-1:0]   w_cnt_next;
    logic [W-1:0]   w_div_next;
    logic [W-1:0]   w_pend_next;
    logic           w_handshake;
    logic           w_terminal;
    logic           w_run_next;
    logic           w_div_clk_next;
    logic           w_tick_next;

    // Ready is a pure decode of state: only a parked ratio blocks new requests.
    assign io_cfgReady = (r_state != ST_PEND);
    assign w_handshake = io_cfgValid && io_cfgReady;
    assign w_terminal  = (r_cnt == (r_div - ONE));

    // State register plus counter, ratio registers and the output flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_STOPPED;
            r_cnt     <= '0;
            r_div     <= DEF_DIV;
            r_pend    <= '0;
            r_div_clk <= 1'b0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_div     <= w_div_next;
            r_pend    <= w_pend_next;
            r_div_clk <= w_div_clk_next;
            r_tick    <= w_tick_next;
            r_running <= w_run_next;
        end
    end

    // Next-state, counter and ratio update; the counter only wraps at D-1.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_div_next   = r_div;
        w_pend_next  = r_pend;
        case (r_state)
            ST_STOPPED: begin
                w_cnt_next = '0;
                if (w_handshake) begin
                    w_div_next = clamp_div(io_cfgDiv);
                end
                if (io_en) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_terminal) begin
                    w_cnt_next = '0;
                    if (w_handshake) begin
                        w_div_next = clamp_div(io_cfgDiv);
                    end
                    if (!io_en) begin
                        w_state_next = ST_STOPPED;
                    end
                end else begin
                    w_cnt_next = r_cnt + ONE;
                    if (w_handshake) begin
                        w_pend_next  = clamp_div(io_cfgDiv);
                        w_state_next = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (w_terminal) begin
                    w_cnt_next   = '0;
                    w_div_next   = r_pend;
                    w_state_next = io_en ? ST_RUN : ST_STOPPED;
                end else begin
                    w_cnt_next = r_cnt + ONE;
                end
            end
            default: begin
                w_state_next = ST_STOPPED;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Output flops are loaded from the next-cycle view so they line up with
    // the count they describe.
    always_comb begin
        w_run_next     = (w_state_next != ST_STOPPED);
        w_div_clk_next = w_run_next && (w_cnt_next < (w_div_next >> 1));
        w_tick_next    = w_run_next && (w_cnt_next == (w_div_next - ONE));
    end

    assign io_divClk  = r_div_clk;
    assign io_tick    = r_tick;
    assign io_running = r_running;
    assign io_curDiv  = r_div;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: directed scenarios with literal expectations
// followed by randomized stimulus against a period-level reference model.
module tb_prog_clk_divider;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         en;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_div;
    logic         div_clk;
    logic         tick;
    logic         running;
    logic [W-1:0] cur_div;

    int n_checks = 0;
    int n_fail   = 0;

    prog_clk_divider #(.W(W), .DEFAULT_DIV(4)) dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .io_en       (en),
        .io_cfgValid (cfg_valid),
        .io_cfgReady (cfg_ready),
        .io_cfgDiv   (cfg_div),
        .io_divClk   (div_clk),
        .io_tick     (tick),
        .io_running  (running),
        .io_curDiv   (cur_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: is the divider running, where are we in the period,
    // the period length, and an optional ratio waiting for the boundary.
    bit m_run    = 1'b0;
    bit m_pend   = 1'b0;
    int m_pos    = 0;
    int m_len    = 4;
    int m_next   = 0;

    function automatic int clampv(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    always @(posedge clk) begin
        bit accept;
        if (!reset_n) begin
            m_run = 1'b0; m_pend = 1'b0; m_pos = 0; m_len = 4; m_next = 0;
        end else begin
            accept = cfg_valid && !m_pend;
            if (accept)
                $display("cfg request div=%0d accepted (running=%0d pos=%0d) at %0t",
                         cfg_div, m_run, m_pos, $time);
            if (!m_run) begin
                if (accept) m_len = clampv(int'(cfg_div));
                if (en) begin m_run = 1'b1; m_pos = 0; end
            end else if (m_pos == m_len - 1) begin
                m_pos = 0;
                if (m_pend) begin m_len = m_next; m_pend = 1'b0; end
                else if (accept) m_len = clampv(int'(cfg_div));
                if (!en) m_run = 1'b0;
            end else begin
                m_pos = m_pos + 1;
                if (accept) begin m_pend = 1'b1; m_next = clampv(int'(cfg_div)); end
            end
        end
        #1;
        check("divClk",   int'(div_clk),   int'(m_run && (m_pos < m_len / 2)));
        check("tick",     int'(tick),      int'(m_run && (m_pos == m_len - 1)));
        check("running",  int'(running),   int'(m_run));
        check("cfgReady", int'(cfg_ready), int'(!m_pend));
        check("curDiv",   int'(cur_div),   m_len);
    end

    // Advance to just after the next edge; inputs set here are sampled at the following edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [15:0] dc, tk, rn;

    task automatic capture();
        dc = {dc[14:0], div_clk};
        tk = {tk[14:0], tick};
        rn = {rn[14:0], running};
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        dc = '0; tk = '0; rn = '0;

        // Reset held for 3 cycles then released.
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        check("rst_divClk", int'(div_clk), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_running", int'(running), 0);
        check("rst_cfgReady", int'(cfg_ready), 1);
        check("rst_curDiv", int'(cur_div), 4);

        // D=4 free-running.
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin step(); capture(); end
        check("d4_divClk", int'(dc[7:0]), 8'b11001100);
        check("d4_tick", int'(tk[7:0]), 8'b00010001);
        check("d4_running", int'(rn[7:0]), 8'hff);

        // Drop en at cnt=1: the period still completes.
        step(); capture();
        step(); capture(); en = 1'b0;
        step(); capture();
        step(); capture();
        step(); capture();
        check("stop_divClk", int'(dc[4:0]), 5'b11000);
        check("stop_tick", int'(tk[4:0]), 5'b00010);
        check("stop_running", int'(rn[4:0]), 5'b11110);
        step();
        check("stopped_running", int'(running), 0);
        check("stopped_divClk", int'(div_clk), 0);

        // Ratio 5 loaded while stopped, then restart.
        cfg_valid = 1'b1; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0;
        check("load5_curDiv", int'(cur_div), 5);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin step(); capture(); end
        check("d5_divClk", int'(dc[9:0]), 10'b1100011000);
        check("d5_tick", int'(tk[9:0]), 10'b0000100001);

        // Terminal-cycle handshake back to 4, then mid-period request for 6.
        check("term_ready", int'(cfg_ready), 1);
        cfg_valid = 1'b1; cfg_div = 8'd4;
        step();
        cfg_valid = 1'b0;
        check("d4b_curDiv", int'(cur_div), 4);
        step();
        cfg_valid = 1'b1; cfg_div = 8'd6;
        step();
        cfg_valid = 1'b0;
        check("pend_ready_c2", int'(cfg_ready), 0);
        check("pend_curDiv", int'(cur_div), 4);
        step();
        check("pend_ready_c3", int'(cfg_ready), 0);
        step(); capture();
        check("d6_ready", int'(cfg_ready), 1);
        check("d6_curDiv", int'(cur_div), 6);
        for (int i = 0; i < 5; i++) begin step(); capture(); end
        check("d6_divClk", int'(dc[5:0]), 6'b111000);
        check("d6_tick", int'(tk[5:0]), 6'b000001);

        // Ratio 1 in the terminal cycle clamps to 2.
        cfg_valid = 1'b1; cfg_div = 8'd1;
        check("clamp_ready", int'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        capture();
        for (int i = 0; i < 3; i++) begin step(); capture(); end
        check("d2_divClk", int'(dc[3:0]), 4'b1010);
        check("d2_tick", int'(tk[3:0]), 4'b0101);
        check("d2_curDiv", int'(cur_div), 2);
        check("d2_ready", int'(cfg_ready), 1);

        // Reset pulse mid-period forces outputs at once.
        step();
        check("pre_rst_divClk", int'(div_clk), 1);
        reset_n = 1'b0;
        #1;
        check("async_divClk", int'(div_clk), 0);
        check("async_running", int'(running), 0);
        check("async_curDiv", int'(cur_div), 4);
        check("async_ready", int'(cfg_ready), 1);
        step(); step();
        reset_n = 1'b1;

        // Randomized run checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            step();
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) reset_n = 1'b0;
            en        = ($urandom_range(0, 99) < 85);
            cfg_valid = ($urandom_range(0, 99) < 25);
            cfg_div   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                    : W'($urandom_range(0, 12));
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
